video_timing_gen: RTL
=====================

Name: video_timing_gen

Overview:
Upstream stage of the per-channel TMDS encoders. It generates raster timing (DE, HSYNC, VSYNC), issues pixel read requests with x/y coordinates to the frame source, and re-aligns the returned 24-bit RGB with the timing signals. Its outputs map directly onto encoder inputs: o_de to data-enable, o_c to the channel-0 control pair, and o_red/o_green/o_blue to the three data channels. It runs in the pixel clock domain.

Parameters:
H_ACTIVE, 640, visible pixels per line (must be a multiple of 8)
H_FP, 16, horizontal front porch in clocks
H_SYNC, 96, horizontal sync width in clocks
H_BP, 48, horizontal back porch in clocks
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vertical sync width in lines
V_BP, 33, vertical back porch in lines
HSYNC_POL, 0, asserted level of HSYNC (0 = active-low)
VSYNC_POL, 0, asserted level of VSYNC (0 = active-low)

Ports:
i_clk  in  1  pixel clock; all logic on the rising edge
i_rst  in  1  synchronous, active-high reset
i_pixel  in  24  {R,G,B} returned by the source, valid exactly 1 cycle after o_req
i_pattern  in  1  selects the internal colour bars (see Optional Feature)
o_req  out  1  pixel request; high for every active (x,y)
o_x  out  12  requested column, valid while o_req is high
o_y  out  12  requested row, valid while o_req is high
o_de  out  1  data enable to the encoders
o_c  out  2  encoder control pair: bit0 = HSYNC level, bit1 = VSYNC level
o_red  out  8  red channel data
o_green  out  8  green channel data
o_blue  out  8  blue channel data
o_line_start  out  1  one-cycle pulse on the first DE pixel of each line
o_frame_start  out  1  one-cycle pulse on pixel (0,0) at the DE stage

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL are computed the same way. Both must be ≤ 4096. Counters h_cnt and v_cnt are 12 bits wide.
- Horizontal FSM states: ACTIVE, FP, SYNC, BP. Each state lasts its parameter length in clocks. BP→ACTIVE wraps h_cnt to 0 and advances v_cnt. When v_cnt = V_TOTAL-1, it wraps to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- HSYNC is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- VSYNC is asserted for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC). It changes only at h_cnt = 0.
- Pipeline stage 0 is the counters.
- Stage 1 is registered: o_req, o_x = h_cnt, o_y = v_cnt. When o_req = 0, o_x and o_y hold 0.
- Stage 2 is registered: DE, sync and RGB.
  - i_pixel is sampled in the cycle after o_req.
  - o_de, o_c, o_red/o_green/o_blue, o_line_start and o_frame_start all appear 2 cycles after the counter state that produced them, and 1 cycle after the matching o_req.
  - DE and sync are delayed through matching registers so all stage-2 outputs stay aligned.
- Whenever o_de = 0, o_red, o_green and o_blue are forced to 0.
- o_c bits carry polarity-applied levels: a deasserted sync equals ~POL.
- Reset: while i_rst is high, all of the following hold every cycle:
  - h_cnt = v_cnt = 0
  - o_req = o_de = o_line_start = o_frame_start = 0
  - o_x = o_y = 0 and RGB = 0
  - o_c = {~VSYNC_POL, ~HSYNC_POL}
- Release from reset:
  - Cycle 1 (the first edge with i_rst low): o_req = 1 with (0,0).
  - Cycle 2: o_de = 1 and o_frame_start = 1.
- Reset asserted mid-frame takes effect on the next edge. Pipeline contents are discarded and no partial line is emitted after release.
- Parameters are static; there is no runtime reconfiguration.

Optional Feature:
Macro VIDEO_TIMING_GEN_PATTERN_EN.

Defined:
- i_pattern is sampled only at the stage-1 cycle of pixel (0,0), so the selection switches per frame with no tearing.
- When sampled high, stage 2 outputs 8 vertical bars of width H_ACTIVE/8 instead of i_pixel. Bar order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- The bar index comes from an incrementing bar counter, not a divider.
- o_req still toggles normally.

Undefined:
- i_pattern is ignored and i_pixel is always used.

Test Plan:
1. Defaults, release reset → cycle 1: o_req = 1, o_x = 0, o_y = 0; cycle 2: o_de = 1, o_frame_start = 1, o_line_start = 1; o_c = 2'b11 throughout reset.
2. Line timing → o_de high 640 cycles then low 160 cycles (period 800); o_c[0] = 0 for 96 cycles starting 16 cycles after o_de falls; o_req leads o_de by exactly 1 cycle.
3. Frame timing → 480 DE bursts per frame; o_c[1] = 0 for 1600 cycles starting at the stage-2 cycle of line 490, h = 0; o_frame_start period 420000 cycles.
4. Data path → model returns {o_x[7:0], o_y[7:0], 8'hA5} 1 cycle after o_req; RGB must match on every o_de cycle (e.g. x = 200, y = 37 → C8_25_A5) and be 000000 while o_de = 0.
5. Assert i_rst for 1 cycle at h = 300, v = 100 → next cycle o_de = 0, o_req = 0, o_c = 11; after release, the first o_req is at (0,0) and the first o_frame_start occurs 2 cycles after release.
6. With the macro defined, i_pattern = 1 before frame start → x 0–79 = FFFFFF, x 80–159 = FFFF00, …, x 560–639 = 000000; i_pattern dropped mid-frame → bars persist until the next frame.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing, pixel request and RGB re-alignment feeding the TMDS encoders.
// Optional colour-bar source enabled by VIDEO_TIMING_GEN_PATTERN_EN.
module video_timing_gen #(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FP      = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BP      = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FP      = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BP      = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [23:0] i_pixel,
   input  logic        i_pattern,
   output logic        o_req,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_de,
   output logic [1:0]  o_c,
   output logic [7:0]  o_red,
   output logic [7:0]  o_green,
   output logic [7:0]  o_blue,
   output logic        o_line_start,
   output logic        o_frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] HA_LAST  = 12'(H_ACTIVE - 1);
   localparam logic [11:0] HFP_LAST = 12'(H_ACTIVE + H_FP - 1);
   localparam logic [11:0] HSY_LAST = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [11:0] HT_LAST  = 12'(H_TOTAL - 1);
   localparam logic [11:0] VA       = 12'(V_ACTIVE);
   localparam logic [11:0] VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] VT_LAST  = 12'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      H_ACT,
      H_FPS,
      H_SYN,
      H_BPS
   } hstate_e;

   hstate_e     state_q, state_d;
   logic [11:0] h_cnt_q, h_cnt_d;
   logic [11:0] v_cnt_q, v_cnt_d;

   logic active_w;
   logic hsync_w;
   logic vsync_w;

   // Stage 0: horizontal FSM with its position counters
   always_comb begin
      state_d = state_q;
      h_cnt_d = h_cnt_q + 12'd1;
      v_cnt_d = v_cnt_q;
      unique case (state_q)
         H_ACT: if (h_cnt_q == HA_LAST) state_d = H_FPS;
         H_FPS: if (h_cnt_q == HFP_LAST) state_d = H_SYN;
         H_SYN: if (h_cnt_q == HSY_LAST) state_d = H_BPS;
         H_BPS: begin
            if (h_cnt_q == HT_LAST) begin
               state_d = H_ACT;
               h_cnt_d = '0;
               v_cnt_d = (v_cnt_q == VT_LAST) ? '0 : v_cnt_q + 12'd1;
            end
         end
         default: state_d = H_ACT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= H_ACT;
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

   assign active_w = (state_q == H_ACT) && (v_cnt_q < VA);
   assign hsync_w  = (state_q == H_SYN);
   assign vsync_w  = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

   // Stage 1: request plus timing flags waiting for the pixel
   logic        req_q;
   logic [11:0] x_q, y_q;
   logic        hs1_q, vs1_q, ls1_q, fs1_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         req_q <= 1'b0;
         x_q   <= '0;
         y_q   <= '0;
         hs1_q <= 1'b0;
         vs1_q <= 1'b0;
         ls1_q <= 1'b0;
         fs1_q <= 1'b0;
      end else begin
         req_q <= active_w;
         x_q   <= active_w ? h_cnt_q : '0;
         y_q   <= active_w ? v_cnt_q : '0;
         hs1_q <= hsync_w;
         vs1_q <= vsync_w;
         ls1_q <= active_w && (h_cnt_q == '0);
         fs1_q <= active_w && (h_cnt_q == '0) && (v_cnt_q == '0);
      end
   end

   logic [23:0] pix_w;

`ifdef VIDEO_TIMING_GEN_PATTERN_EN
   localparam logic [11:0] BAR_LAST = 12'(H_ACTIVE / 8 - 1);

   logic [11:0] bcnt_q;
   logic [2:0]  bar_q, bar1_q;
   logic        pat_q;
   logic [23:0] bar_rgb;

   // Bar index tracks h_cnt; wraps to 0 after eight bars and at line end
   always_ff @(posedge i_clk) begin
      if (i_rst || (h_cnt_d == '0)) begin
         bcnt_q <= '0;
         bar_q  <= '0;
      end else if (state_q == H_ACT) begin
         if (bcnt_q == BAR_LAST) begin
            bcnt_q <= '0;
            bar_q  <= bar_q + 3'd1;
         end else begin
            bcnt_q <= bcnt_q + 12'd1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         bar1_q <= '0;
         pat_q  <= 1'b0;
      end else begin
         bar1_q <= bar_q;
         if (active_w && (h_cnt_q == '0) && (v_cnt_q == '0))
            pat_q <= i_pattern;
      end
   end

   always_comb begin
      bar_rgb = 24'h000000;
      case (bar1_q)
         3'd0:    bar_rgb = 24'hFFFFFF;
         3'd1:    bar_rgb = 24'hFFFF00;
         3'd2:    bar_rgb = 24'h00FFFF;
         3'd3:    bar_rgb = 24'h00FF00;
         3'd4:    bar_rgb = 24'hFF00FF;
         3'd5:    bar_rgb = 24'hFF0000;
         3'd6:    bar_rgb = 24'h0000FF;
         default: bar_rgb = 24'h000000;
      endcase
   end

   assign pix_w = pat_q ? bar_rgb : i_pixel;
`else
   logic unused_pattern;
   assign unused_pattern = i_pattern;
   assign pix_w = i_pixel;
`endif

   // Stage 2: encoder-facing registers, all aligned to the returned pixel
   logic        de_q;
   logic [1:0]  c_q;
   logic [23:0] rgb_q;
   logic        ls2_q, fs2_q;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         de_q  <= 1'b0;
         c_q   <= {~VSYNC_POL, ~HSYNC_POL};
         rgb_q <= '0;
         ls2_q <= 1'b0;
         fs2_q <= 1'b0;
      end else begin
         de_q  <= req_q;
         c_q   <= {vs1_q ? VSYNC_POL : ~VSYNC_POL,
                   hs1_q ? HSYNC_POL : ~HSYNC_POL};
         rgb_q <= req_q ? pix_w : '0;
         ls2_q <= ls1_q;
         fs2_q <= fs1_q;
      end
   end

   assign o_req         = req_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_de          = de_q;
   assign o_c           = c_q;
   assign o_red         = rgb_q[23:16];
   assign o_green       = rgb_q[15:8];
   assign o_blue        = rgb_q[7:0];
   assign o_line_start  = ls2_q;
   assign o_frame_start = fs2_q;

endmodule
